orientation_rx: RTL

- Front-end stage feeding the cube display core: receives the 162-bit cube orientation from the microcontroller over a 3-wire link (sck, sdi, load).
- All inputs are oversampled in the clk domain; no logic is clocked by sck.
- Holds the last good frame in a shadow register and presents it on `orientation` with a one-cycle `frame_valid` strobe. This strobe replaces the display core's reset-pulse generator.
- Reports display completion back to the microcontroller on `done_out`, and flags malformed frames.

---
 rtl/orientation_rx.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/orientation_rx.sv
// Receives the 162-bit cube orientation over sck/sdi/load, oversampled in the clk domain.
// Holds the last good frame and reports display completion back to the MCU on done_out.
module orientation_rx #(
  parameter int NBITS       = 162,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sck,
  input  logic             sdi,
  input  logic             load,
  input  logic             disp_done,
  output logic [NBITS-1:0] orientation,
  output logic             frame_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             done_out
);

  localparam int            CW   = $clog2(NBITS + 1);
  localparam logic [CW-1:0] FULL = CW'(NBITS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT     = 2'd1,
    WAIT_DISP = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic [SYNC_STAGES-1:0] load_sync_q, load_sync_d;
  logic                   sck_p_q, sck_p_d;
  logic                   load_p_q, load_p_d;

  state_e                 state_q, state_d;
  logic [NBITS-1:0]       sr_q, sr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [NBITS-1:0]       orient_q, orient_d;
  logic                   commit_q, commit_d;
  logic                   discard_q, discard_d;
  logic                   frame_valid_q, frame_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic sck_s, sdi_s, load_s;
  logic sck_rise, load_rise, load_fall;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s  = sdi_sync_q[SYNC_STAGES-1];
  assign load_s = load_sync_q[SYNC_STAGES-1];

  assign sck_rise  =  sck_s  & ~sck_p_q;
  assign load_rise =  load_s & ~load_p_q;
  assign load_fall = ~load_s &  load_p_q;

  always_comb begin
    // NOTE: every signal written here gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    sck_sync_d    = {sck_sync_q[SYNC_STAGES-2:0], sck};
    sdi_sync_d    = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
    load_sync_d   = {load_sync_q[SYNC_STAGES-2:0], load};
    sck_p_d       = sck_s;
    load_p_d      = load_s;

    state_d       = state_q;
    sr_d          = sr_q;
    cnt_d         = cnt_q;
    ovf_d         = ovf_q;
    orient_d      = orient_q;
    busy_d        = busy_q;
    done_d        = done_q;
    commit_d      = 1'b0;
    discard_d     = 1'b0;
    frame_valid_d = commit_q;
    frame_err_d   = discard_q;

    // The verdict on a frame is taken at load_fall; the shadow register and
    // the handshake level update together one cycle later.
    if (commit_q) begin
      orient_d = sr_q;
      done_d   = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (load_rise) begin
          state_d = SHIFT;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end

      SHIFT: begin
        if (load_fall) begin
          busy_d = 1'b0;
          if (cnt_q == FULL && !ovf_q) begin
            commit_d = 1'b1;
            state_d  = WAIT_DISP;
          end else begin
            discard_d = 1'b1;
            state_d   = IDLE;
          end
        end else if (sck_rise && load_s) begin
          if (cnt_q < FULL) begin
            sr_d  = {sr_q[NBITS-2:0], sdi_s};
            cnt_d = cnt_q + CW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
      end

      WAIT_DISP: begin
        // A completion cannot belong to a frame that has not been presented yet.
        if (disp_done && !commit_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        if (load_rise) begin
          state_d = SHIFT;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every flop samples the values
    // from before this edge regardless of statement order.
    if (!reset) begin
      sck_sync_q    <= '0;
      sdi_sync_q    <= '0;
      load_sync_q   <= '0;
      sck_p_q       <= 1'b0;
      load_p_q      <= 1'b0;
      state_q       <= IDLE;
      sr_q          <= '0;
      cnt_q         <= '0;
      ovf_q         <= 1'b0;
      orient_q      <= '0;
      commit_q      <= 1'b0;
      discard_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b1;
    end else begin
      sck_sync_q    <= sck_sync_d;
      sdi_sync_q    <= sdi_sync_d;
      load_sync_q   <= load_sync_d;
      sck_p_q       <= sck_p_d;
      load_p_q      <= load_p_d;
      state_q       <= state_d;
      sr_q          <= sr_d;
      cnt_q         <= cnt_d;
      ovf_q         <= ovf_d;
      orient_q      <= orient_d;
      commit_q      <= commit_d;
      discard_q     <= discard_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign orientation = orient_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;
  assign done_out    = done_q;

endmodule
